// File: rtl/battleship_pkg.sv
// Shared types and helpers for the Keyboard Battleship turn sequencer.
package battleship_pkg;

   // Key bus width: A-Z plus 0-9, one bit per key.
   localparam int KEY_W  = 36;
   // Width of the per-player hit counters.
   localparam int HITS_W = 6;

   // Turn sequencer states; encodings are shown on the display.
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_AIM      = 3'd1,
      ST_RESOLVE  = 3'd2,
      ST_RESULT   = 3'd3,
      ST_GAMEOVER = 3'd4
   } turn_state_t;

   // True when exactly one bit of the key code is set.
   function automatic logic is_onehot(input logic [KEY_W-1:0] v);
      logic [KEY_W-1:0] one;
      one = {{(KEY_W-1){1'b0}}, 1'b1};
      return (v != '0) && ((v & (v - one)) == '0);
   endfunction

endpackage

// File: rtl/key_latch.sv
// Key event detector and target register. A key event is a one-hot code
// that differs from the code seen on the previous cycle; while enabled, an
// event loads the target. A synchronous clear wins over a load.
module key_latch
   import battleship_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [KEY_W-1:0] keys_code_i,
   input  logic             en_i,
   input  logic             clr_i,
   output logic [KEY_W-1:0] target_o
);

   logic [KEY_W-1:0] prev_key_q;
   logic [KEY_W-1:0] target_q;
   logic [KEY_W-1:0] target_d;
   logic             key_event;

   // An event needs a single key and a change from last cycle, so a held
   // key or a multi-key chord never reloads the target.
   assign key_event = is_onehot(keys_code_i) && (keys_code_i != prev_key_q);

   // Track the raw key bus every cycle, regardless of game state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_key_q <= '0;
      else        prev_key_q <= keys_code_i;
   end

   // Target next-state: clear first, then a qualified key event.
   always_comb begin
      target_d = target_q;
      if (clr_i)                 target_d = '0;
      else if (en_i && key_event) target_d = keys_code_i;
   end

   // Target register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) target_q <= '0;
      else        target_q <= target_d;
   end

   assign target_o = target_q;

endmodule

// File: rtl/turn_controller.sv
// Two-player Keyboard Battleship turn sequencer: latches an aiming key,
// resolves accepted fire strobes against the opponent's ship map, holds the
// result for RESULT_CYCLES and alternates players until one side wins.
//
// Strobe semantics: fire and start are single-cycle pulses with no
// back-pressure. A strobe is consumed on the edge where it is high only if
// the FSM can act on it in that state (fire in AIM with a fresh, non-zero
// target; start in IDLE/GAMEOVER); otherwise it is dropped, never queued.
module turn_controller
   import battleship_pkg::*;
#(
   parameter int RESULT_CYCLES = 50_000_000,
   parameter int SHIP_CELLS    = 9,
   parameter int CNT_W         = 26
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [KEY_W-1:0]  keys_code,
   input  logic              fire,
   input  logic              start,
   input  logic [KEY_W-1:0]  ship_map_p0,
   input  logic [KEY_W-1:0]  ship_map_p1,
   output logic [KEY_W-1:0]  target_key,
   output logic              cur_player,
   output logic [KEY_W-1:0]  shots_on_p0,
   output logic [KEY_W-1:0]  shots_on_p1,
   output logic [HITS_W-1:0] hits_p0,
   output logic [HITS_W-1:0] hits_p1,
   output logic              hit_pulse,
   output logic              miss_pulse,
   output logic              game_over,
   output logic              winner,
   output logic [2:0]        state
);

   localparam logic [HITS_W-1:0] SHIP_LIMIT = HITS_W'(SHIP_CELLS);
   localparam logic [CNT_W-1:0]  TIMER_LAST = CNT_W'(RESULT_CYCLES - 1);

   turn_state_t       state_q, state_d;
   logic              cur_player_q, cur_player_d;
   logic [KEY_W-1:0]  shots_p0_q, shots_p0_d;
   logic [KEY_W-1:0]  shots_p1_q, shots_p1_d;
   logic [HITS_W-1:0] hits_p0_q, hits_p0_d;
   logic [HITS_W-1:0] hits_p1_q, hits_p1_d;
   logic              hit_q, hit_d;
   logic              miss_q, miss_d;
   logic              game_over_q, game_over_d;
   logic              winner_q, winner_d;
   logic [CNT_W-1:0]  timer_q, timer_d;

   logic [KEY_W-1:0]  target;
   logic [KEY_W-1:0]  opp_shots;
   logic [KEY_W-1:0]  opp_ships;
   logic [HITS_W-1:0] cur_hits;
   logic              fire_ok;
   logic              start_ok;
   logic              timer_done;
   logic              win;
   logic              shot_hits;
   logic              latch_en;
   logic              latch_clr;

   // The opponent of player 0 is player 1 and vice versa.
   assign opp_shots  = cur_player_q ? shots_p0_q  : shots_p1_q;
   assign opp_ships  = cur_player_q ? ship_map_p0 : ship_map_p1;
   assign cur_hits   = cur_player_q ? hits_p1_q   : hits_p0_q;
   assign shot_hits  = (target & opp_ships) != '0;
   assign timer_done = (timer_q == TIMER_LAST);
   assign win        = (cur_hits == SHIP_LIMIT);

   // A cell can be fired upon only once; a blank target is never fired.
   assign fire_ok  = (state_q == ST_AIM) && fire && (target != '0) &&
                     ((target & opp_shots) == '0);
   assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_GAMEOVER));

   // An accepted fire freezes the target, so a key pressed on the same edge
   // is discarded. The target is wiped for a new game and on turn handover.
   assign latch_en  = (state_q == ST_AIM) && !fire_ok;
   assign latch_clr = start_ok ||
                      ((state_q == ST_RESULT) && timer_done && !win);

   key_latch u_key_latch (
      .clk        (clk),
      .rst_n      (rst_n),
      .keys_code_i(keys_code),
      .en_i       (latch_en),
      .clr_i      (latch_clr),
      .target_o   (target)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:     if (start_ok) state_d = ST_AIM;
         ST_AIM:      if (fire_ok)  state_d = ST_RESOLVE;
         ST_RESOLVE:  state_d = ST_RESULT;
         ST_RESULT:   if (timer_done) state_d = win ? ST_GAMEOVER : ST_AIM;
         ST_GAMEOVER: if (start_ok) state_d = ST_AIM;
         default:     state_d = ST_IDLE;
      endcase
   end

   // FSM output logic: next values of the registered game outputs.
   always_comb begin
      cur_player_d = cur_player_q;
      shots_p0_d   = shots_p0_q;
      shots_p1_d   = shots_p1_q;
      hits_p0_d    = hits_p0_q;
      hits_p1_d    = hits_p1_q;
      hit_d        = 1'b0;
      miss_d       = 1'b0;
      game_over_d  = game_over_q;
      winner_d     = winner_q;
      timer_d      = '0;

      if (start_ok) begin
         cur_player_d = 1'b0;
         shots_p0_d   = '0;
         shots_p1_d   = '0;
         hits_p0_d    = '0;
         hits_p1_d    = '0;
         game_over_d  = 1'b0;
         winner_d     = 1'b0;
      end

      unique case (state_q)
         ST_RESOLVE: begin
            if (cur_player_q) shots_p0_d = shots_p0_q | target;
            else              shots_p1_d = shots_p1_q | target;
            if (shot_hits) begin
               hit_d = 1'b1;
               // Counters stop at the winning count.
               if (cur_player_q) begin
                  if (hits_p1_q < SHIP_LIMIT) hits_p1_d = hits_p1_q + 1'b1;
               end else begin
                  if (hits_p0_q < SHIP_LIMIT) hits_p0_d = hits_p0_q + 1'b1;
               end
            end else begin
               miss_d = 1'b1;
            end
         end
         ST_RESULT: begin
            if (timer_done) begin
               if (win) begin
                  winner_d    = cur_player_q;
                  game_over_d = 1'b1;
               end else begin
                  cur_player_d = ~cur_player_q;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Registered game outputs and result timer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_player_q <= 1'b0;
         shots_p0_q   <= '0;
         shots_p1_q   <= '0;
         hits_p0_q    <= '0;
         hits_p1_q    <= '0;
         hit_q        <= 1'b0;
         miss_q       <= 1'b0;
         game_over_q  <= 1'b0;
         winner_q     <= 1'b0;
         timer_q      <= '0;
      end else begin
         cur_player_q <= cur_player_d;
         shots_p0_q   <= shots_p0_d;
         shots_p1_q   <= shots_p1_d;
         hits_p0_q    <= hits_p0_d;
         hits_p1_q    <= hits_p1_d;
         hit_q        <= hit_d;
         miss_q       <= miss_d;
         game_over_q  <= game_over_d;
         winner_q     <= winner_d;
         timer_q      <= timer_d;
      end
   end

   assign target_key  = target;
   assign cur_player  = cur_player_q;
   assign shots_on_p0 = shots_p0_q;
   assign shots_on_p1 = shots_p1_q;
   assign hits_p0     = hits_p0_q;
   assign hits_p1     = hits_p1_q;
   assign hit_pulse   = hit_q;
   assign miss_pulse  = miss_q;
   assign game_over   = game_over_q;
   assign winner      = winner_q;
   assign state       = state_q;

endmodule

// File: tb/tb_turn_controller.sv
// Bench for turn_controller with a 4-cycle result hold and 2-cell fleets.
module tb_turn_controller;
   import battleship_pkg::*;

   localparam int RW = 44; // {hit, shooter, shooter hits[5:0], opponent shots[35:0]}

   logic              clk;
   logic              rst_n;
   logic [KEY_W-1:0]  keys_code;
   logic              fire;
   logic              start;
   logic [KEY_W-1:0]  ship_map_p0;
   logic [KEY_W-1:0]  ship_map_p1;
   logic [KEY_W-1:0]  target_key;
   logic              cur_player;
   logic [KEY_W-1:0]  shots_on_p0;
   logic [KEY_W-1:0]  shots_on_p1;
   logic [HITS_W-1:0] hits_p0;
   logic [HITS_W-1:0] hits_p1;
   logic              hit_pulse;
   logic              miss_pulse;
   logic              game_over;
   logic              winner;
   logic [2:0]        state;

   logic [RW-1:0] exp_q[$];
   int tests;
   int fails;
   int mon_tests;
   int mon_fails;

   turn_controller #(
      .RESULT_CYCLES(4),
      .SHIP_CELLS   (2),
      .CNT_W        (26)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .keys_code  (keys_code),
      .fire       (fire),
      .start      (start),
      .ship_map_p0(ship_map_p0),
      .ship_map_p1(ship_map_p1),
      .target_key (target_key),
      .cur_player (cur_player),
      .shots_on_p0(shots_on_p0),
      .shots_on_p1(shots_on_p1),
      .hits_p0    (hits_p0),
      .hits_p1    (hits_p1),
      .hit_pulse  (hit_pulse),
      .miss_pulse (miss_pulse),
      .game_over  (game_over),
      .winner     (winner),
      .state      (state)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driver tasks
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input logic [KEY_W-1:0] k);
      keys_code = k;
      step(1);
      keys_code = '0;
   endtask

   task automatic pull_fire();
      fire = 1'b1;
      step(1);
      fire = 1'b0;
   endtask

   task automatic pull_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [RW-1:0] rec(input logic h, input logic p,
                                         input logic [HITS_W-1:0] n,
                                         input logic [KEY_W-1:0] s);
      return {h, p, n, s};
   endfunction

   // Scoreboard monitor: every shot result pulse is compared against the
   // oldest expected shot outcome.
   always @(negedge clk) begin
      if (rst_n && (hit_pulse || miss_pulse)) begin
         logic [RW-1:0] act;
         act = {hit_pulse, cur_player, cur_player ? hits_p1 : hits_p0,
                cur_player ? shots_on_p0 : shots_on_p1};
         mon_tests++;
         if (hit_pulse && miss_pulse) begin
            mon_fails++;
            $display("FAIL both_pulses: got hit=1 miss=1 expected one of them");
         end else if (exp_q.size() == 0) begin
            mon_fails++;
            $display("FAIL unexpected_shot: got %0h expected no shot", act);
         end else begin
            logic [RW-1:0] exp;
            exp = exp_q.pop_front();
            if (act !== exp) begin
               mon_fails++;
               $display("FAIL shot_result: got %0h expected %0h", act, exp);
            end
         end
      end
   end

   // Directed stimulus
   initial begin
      tests = 0; fails = 0; mon_tests = 0; mon_fails = 0;
      rst_n = 1'b0; keys_code = '0; fire = 1'b0; start = 1'b0;
      ship_map_p0 = 36'h300;
      ship_map_p1 = 36'h3;
      step(2);
      check("rst_state", state, 0);
      check("rst_target", target_key, 0);
      check("rst_cur", cur_player, 0);
      check("rst_game_over", game_over, 0);
      check("rst_hits", {hits_p0, hits_p1}, 0);
      rst_n = 1'b1;
      step(1);

      // New game and first aim.
      pull_start();
      check("start_state", state, 1);
      check("start_cur", cur_player, 0);
      press(36'h1);
      check("key_load", target_key, 36'h1);

      // Multi-hot ignored, then a held key loads once.
      keys_code = 36'h3;
      step(1);
      check("multihot_ignored", target_key, 36'h1);
      keys_code = 36'h4;
      step(1);
      check("held_key_load", target_key, 36'h4);
      step(4);
      check("held_key_keep", target_key, 36'h4);
      keys_code = '0;
      step(1);

      // P0 hits P1 at cell 1.
      press(36'h1);
      exp_q.push_back(rec(1'b1, 1'b0, 6'd1, 36'h1));
      pull_fire();
      check("resolve_state", state, 2);
      step(1);
      check("result_state", state, 3);
      step(1);
      check("pulse_one_cycle", {hit_pulse, miss_pulse}, 0);
      step(2);
      check("result_hold", state, 3);
      step(1);
      check("turn_pass_state", state, 1);
      check("turn_pass_cur", cur_player, 1);
      check("turn_pass_target", target_key, 0);

      // P1 misses at empty cell 8.
      press(36'h8);
      exp_q.push_back(rec(1'b0, 1'b1, 6'd0, 36'h8));
      pull_fire();
      step(5);
      check("p1_turn_end", {state, 1'b0, cur_player}, {3'd1, 1'b0, 1'b0});

      // P0 re-fires an already shot cell: ignored.
      press(36'h1);
      pull_fire();
      check("refire_ignored", state, 1);

      // P0 sinks the last cell and wins.
      press(36'h2);
      exp_q.push_back(rec(1'b1, 1'b0, 6'd2, 36'h3));
      pull_fire();
      step(4);
      check("no_early_game_over", game_over, 0);
      step(1);
      check("gameover_state", state, 4);
      check("gameover_flag", game_over, 1);
      check("winner", winner, 0);
      step(3);
      check("gameover_hold", {state, hits_p0}, {3'd4, 6'd2});

      // start from GAMEOVER gives a clean game.
      pull_start();
      check("restart_state", state, 1);
      check("restart_clear", {hits_p0, shots_on_p1, game_over, cur_player},
            {6'd0, 36'h0, 1'b0, 1'b0});

      // Fire with no target is dropped.
      pull_fire();
      check("fire_no_target", state, 1);

      // Same-cycle key and fire resolves the previously held target.
      press(36'h20);
      step(1);
      exp_q.push_back(rec(1'b0, 1'b0, 6'd0, 36'h20));
      keys_code = 36'h10;
      pull_fire();
      check("same_cycle_state", state, 2);
      check("same_cycle_target", target_key, 36'h20);
      step(2);

      // Asynchronous reset in RESULT.
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_state", state, 0);
      check("async_rst_clear", {target_key, shots_on_p1, cur_player, hit_pulse, miss_pulse},
            {36'h0, 36'h0, 1'b0, 1'b0, 1'b0});
      step(1);
      rst_n = 1'b1;
      step(1);

      // Keys are ignored outside AIM.
      press(36'h4);
      check("idle_key_ignored", target_key, 0);
      step(6);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests + mon_tests, fails + mon_fails);
      $finish;
   end

endmodule
